register_file_write_arbiter: RTL and testbench

//  Shares the single write port of the 32 x 64 register file between two write-back sources.

---
 rtl/register_file_write_arbiter_pkg.sv | 36 +++
 rtl/register_file_write_arbiter_if.sv | 20 ++
 rtl/write_request_fifo.sv | 84 ++++++++
 rtl/register_file_write_arbiter.sv | 139 +++++++++++++
 tb/tb_register_file_write_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_write_arbiter_pkg.sv
// Shared constants, grant encoding and small helpers for the register file
// write arbiter. The register file geometry lives here so every file of the
// arbiter agrees on data width, address width, register count and the
// hard-wired zero register.
//   REG_DATA_WIDTH  register file word width (64)
//   REG_ADDR_WIDTH  register address width (5)
//   REG_COUNT       number of registers (32)
//   REG_ZERO        hard-wired zero register (31)
package register_file_write_arbiter_pkg;

  localparam int REG_DATA_WIDTH    = 64;
  localparam int REG_ADDR_WIDTH    = 5;
  localparam int REG_COUNT         = 32;
  localparam int REG_ZERO          = 31;
  localparam int STALL_COUNT_WIDTH = 16;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // One-hot decode of a register address into a pending-bitmap contribution.
  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_WIDTH-1:0] addr);
    reg_onehot = {{(REG_COUNT-1){1'b0}}, 1'b1} << addr;
  endfunction

  // Saturating increment for the stall counters.
  function automatic logic [STALL_COUNT_WIDTH-1:0] sat_inc(input logic [STALL_COUNT_WIDTH-1:0] value);
    if (value == 16'hFFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 16'h0001;
    end
  endfunction

endpackage

// File: rtl/register_file_write_arbiter_if.sv
// Write-request channel from one write-back source to the arbiter.
//   valid    source has a write this cycle
//   ready    arbiter can accept it this cycle
//   address  destination register
//   data     write data
// master: the write-back source; slave: the arbiter.
interface register_file_write_arbiter_if
  import register_file_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output address, output data, input ready);
  modport slave  (input valid, input address, input data, output ready);
endinterface

// File: rtl/write_request_fifo.sv
// Small shift-style request FIFO; entry 0 is always the head. Every slot is
// exposed so the owner can decode which registers have queued writes.
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   push/push_data enqueue (caller guarantees the FIFO was not full)
//   pop            dequeue the head (ignored when empty)
//   head_data      current head entry
//   slot_valid     per-slot occupancy, slot_data the slot contents
//   empty/full     count-based status
module write_request_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [DEPTH-1:0] slot_valid,
  output logic [WIDTH-1:0] slot_data [DEPTH],
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0]       entries_r [DEPTH];
  logic [WIDTH-1:0]       entries_s [DEPTH];
  logic [COUNT_WIDTH-1:0] count_r;
  logic [COUNT_WIDTH-1:0] count_s;
  logic [COUNT_WIDTH-1:0] fill_s;

  assign empty     = (count_r == {COUNT_WIDTH{1'b0}});
  assign full      = (count_r == COUNT_WIDTH'(DEPTH));
  assign head_data = entries_r[0];
  assign slot_data = entries_r;

  // Next state: shift down on pop first, then write the push into the first free slot.
  always_comb begin
    entries_s = entries_r;
    fill_s    = count_r;
    count_s   = count_r;
    if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries_s[i] = entries_r[i + 1];
      end
      entries_s[DEPTH - 1] = {WIDTH{1'b0}};
      fill_s = count_r - COUNT_WIDTH'(1);
    end else begin
      fill_s = count_r;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_s[i] = (fill_s == COUNT_WIDTH'(i)) ? push_data : entries_s[i];
      end
      count_s = fill_s + COUNT_WIDTH'(1);
    end else begin
      count_s = fill_s;
    end
  end

  // Slot occupancy: slots below the count hold live entries.
  always_comb begin
    slot_valid = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = (COUNT_WIDTH'(i) < count_r);
    end
  end

  // Storage and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {COUNT_WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      count_r <= count_s;
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= entries_s[i];
      end
    end
  end

endmodule

// File: rtl/register_file_write_arbiter.sv
// Shares the single register file write port between the ALU (requester A)
// and the load unit (requester B). Each requester has its own request FIFO;
// a round-robin arbiter drains them into registered rf_* signals, and a
// pending-write bitmap tells issue logic which registers have writes in flight.
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   a_port, b_port     write-request channels (valid/ready/address/data)
//   rf_write/address/data  registered register-file write port
//   pending            bit r set while a write to r is queued or on rf_*
//   busy               any FIFO non-empty or rf_write high
// Optional macro REGFILE_ARB_STALL_COUNT_EN adds stall_count_a/stall_count_b,
// saturating 16-bit counts of cycles a requester was held off.
module register_file_write_arbiter
  import register_file_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int ZERO_REG   = REG_ZERO
) (
  input  logic                          clock,
  input  logic                          reset,
  register_file_write_arbiter_if.slave  a_port,
  register_file_write_arbiter_if.slave  b_port,
  output logic                          rf_write,
  output logic [ADDR_WIDTH-1:0]         rf_address,
  output logic [DATA_WIDTH-1:0]         rf_data,
  output logic [REG_COUNT-1:0]          pending,
  output logic                          busy
`ifdef REGFILE_ARB_STALL_COUNT_EN
  ,
  output logic [STALL_COUNT_WIDTH-1:0]  stall_count_a,
  output logic [STALL_COUNT_WIDTH-1:0]  stall_count_b
`endif
);

  localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  logic                   push_a_s, push_b_s;
  logic                   grant_a_s, grant_b_s;
  logic                   empty_a_s, empty_b_s;
  logic                   full_a_s, full_b_s;
  logic [ENTRY_WIDTH-1:0] head_a_s, head_b_s;
  logic [FIFO_DEPTH-1:0]  slot_valid_a_s, slot_valid_b_s;
  logic [ENTRY_WIDTH-1:0] slot_data_a_s [FIFO_DEPTH];
  logic [ENTRY_WIDTH-1:0] slot_data_b_s [FIFO_DEPTH];
  logic [REG_COUNT-1:0]   pending_s;
  grant_e                 last_grant_r;

  // A full FIFO is never ready, even if it pops on the same edge.
  assign a_port.ready = !full_a_s;
  assign b_port.ready = !full_b_s;

  // Zero-register writes complete the handshake but are dropped here.
  assign push_a_s = a_port.valid && !full_a_s && (a_port.address != ADDR_WIDTH'(ZERO_REG));
  assign push_b_s = b_port.valid && !full_b_s && (b_port.address != ADDR_WIDTH'(ZERO_REG));

  write_request_fifo #(.WIDTH(ENTRY_WIDTH), .DEPTH(FIFO_DEPTH)) fifo_a (
    .clock(clock), .reset(reset),
    .push(push_a_s), .push_data({a_port.address, a_port.data}), .pop(grant_a_s),
    .head_data(head_a_s), .slot_valid(slot_valid_a_s), .slot_data(slot_data_a_s),
    .empty(empty_a_s), .full(full_a_s)
  );

  write_request_fifo #(.WIDTH(ENTRY_WIDTH), .DEPTH(FIFO_DEPTH)) fifo_b (
    .clock(clock), .reset(reset),
    .push(push_b_s), .push_data({b_port.address, b_port.data}), .pop(grant_b_s),
    .head_data(head_b_s), .slot_valid(slot_valid_b_s), .slot_data(slot_data_b_s),
    .empty(empty_b_s), .full(full_b_s)
  );

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!empty_a_s && (empty_b_s || (last_grant_r == GRANT_B))) begin
      grant_a_s = 1'b1;
    end else if (!empty_b_s) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Register-file write port; address/data hold their last value when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_write     <= 1'b0;
      rf_address   <= {ADDR_WIDTH{1'b0}};
      rf_data      <= {DATA_WIDTH{1'b0}};
      last_grant_r <= GRANT_B;
    end else if (grant_a_s) begin
      rf_write                <= 1'b1;
      {rf_address, rf_data}   <= head_a_s;
      last_grant_r            <= GRANT_A;
    end else if (grant_b_s) begin
      rf_write                <= 1'b1;
      {rf_address, rf_data}   <= head_b_s;
      last_grant_r            <= GRANT_B;
    end else begin
      rf_write <= 1'b0;
    end
  end

  // Pending bitmap: every live FIFO slot plus the write currently on rf_*.
  always_comb begin
    pending_s = rf_write ? reg_onehot(rf_address) : {REG_COUNT{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pending_s = pending_s |
                  (slot_valid_a_s[i] ? reg_onehot(slot_data_a_s[i][ENTRY_WIDTH-1 -: ADDR_WIDTH])
                                     : {REG_COUNT{1'b0}}) |
                  (slot_valid_b_s[i] ? reg_onehot(slot_data_b_s[i][ENTRY_WIDTH-1 -: ADDR_WIDTH])
                                     : {REG_COUNT{1'b0}});
    end
  end

  assign pending = pending_s;
  assign busy    = !empty_a_s || !empty_b_s || rf_write;

`ifdef REGFILE_ARB_STALL_COUNT_EN
  logic stall_a_s, stall_b_s;

  // Held off either at the handshake (full) or in arbitration (queued but not granted).
  assign stall_a_s = (a_port.valid && full_a_s) || (!empty_a_s && !grant_a_s);
  assign stall_b_s = (b_port.valid && full_b_s) || (!empty_b_s && !grant_b_s);

  // Saturating stall counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_a <= 16'h0000;
      stall_count_b <= 16'h0000;
    end else begin
      stall_count_a <= stall_a_s ? sat_inc(stall_count_a) : stall_count_a;
      stall_count_b <= stall_b_s ? sat_inc(stall_count_b) : stall_count_b;
    end
  end
`endif

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Self-checking bench for register_file_write_arbiter: directed scenarios
// with hand-computed expectations, then randomized traffic, all compared
// every cycle against a queue-based model of the arbiter.
module tb_register_file_write_arbiter;
  import register_file_write_arbiter_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rf_write;
  logic [4:0]  rf_address;
  logic [63:0] rf_data;
  logic [31:0] pending;
  logic        busy;
`ifdef REGFILE_ARB_STALL_COUNT_EN
  logic [15:0] stall_count_a, stall_count_b;
`endif

  always #5 clock = ~clock;

  register_file_write_arbiter_if a_if ();
  register_file_write_arbiter_if b_if ();

  register_file_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .a_port(a_if), .b_port(b_if),
    .rf_write(rf_write), .rf_address(rf_address), .rf_data(rf_data),
    .pending(pending), .busy(busy)
`ifdef REGFILE_ARB_STALL_COUNT_EN
    , .stall_count_a(stall_count_a), .stall_count_b(stall_count_b)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  wr_t         qa[$];
  wr_t         qb[$];
  bit          m_write;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  bit          m_last_b;
  int unsigned m_stall_a, m_stall_b;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_write = 1'b0; m_addr = 5'd0; m_data = 64'd0; m_last_b = 1'b1;
    m_stall_a = 0; m_stall_b = 0;
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = 32'd0;
    foreach (qa[i]) p[qa[i].addr] = 1'b1;
    foreach (qb[i]) p[qb[i].addr] = 1'b1;
    if (m_write) p[m_addr] = 1'b1;
    return p;
  endfunction

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_step();
    bit  ra, rb, ga, gb;
    wr_t e;
    if (!reset) begin
      model_reset();
      return;
    end
    ra = (qa.size() < DEPTH);
    rb = (qb.size() < DEPTH);
    ga = (qa.size() != 0) && ((qb.size() == 0) || m_last_b);
    gb = (qb.size() != 0) && !ga;
    if (((a_if.valid && !ra) || (qa.size() != 0 && !ga)) && m_stall_a < 65535) m_stall_a++;
    if (((b_if.valid && !rb) || (qb.size() != 0 && !gb)) && m_stall_b < 65535) m_stall_b++;
    if (ga) begin
      e = qa.pop_front(); m_write = 1'b1; m_addr = e.addr; m_data = e.data; m_last_b = 1'b0;
    end else if (gb) begin
      e = qb.pop_front(); m_write = 1'b1; m_addr = e.addr; m_data = e.data; m_last_b = 1'b1;
    end else begin
      m_write = 1'b0;
    end
    if (a_if.valid && ra && a_if.address != 5'd31) begin
      e.addr = a_if.address; e.data = a_if.data; qa.push_back(e);
    end
    if (b_if.valid && rb && b_if.address != 5'd31) begin
      e.addr = b_if.address; e.data = b_if.data; qb.push_back(e);
    end
  endtask

  task automatic check_outputs();
    check("a_ready", a_if.ready, qa.size() < DEPTH);
    check("b_ready", b_if.ready, qb.size() < DEPTH);
    check("rf_write", rf_write, m_write);
    check("rf_address", rf_address, m_addr);
    check("rf_data", rf_data, m_data);
    check("pending", pending, model_pending());
    check("busy", busy, (qa.size() != 0) || (qb.size() != 0) || m_write);
`ifdef REGFILE_ARB_STALL_COUNT_EN
    check("stall_count_a", stall_count_a, m_stall_a);
    check("stall_count_b", stall_count_b, m_stall_b);
`endif
  endtask

  task automatic drive(input bit av, input logic [4:0] aa, input logic [63:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [63:0] bd);
    a_if.valid = av; a_if.address = aa; a_if.data = ad;
    b_if.valid = bv; b_if.address = ba; b_if.data = bd;
  endtask

  // One clock: drive while low, step model after the edge, compare on the falling edge.
  task automatic cycle(input bit av, input logic [4:0] aa, input logic [63:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [63:0] bd);
    drive(av, aa, ad, bv, ba, bd);
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic pulse_reset();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #2 reset = 1'b0;
    #1 model_reset();
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    model_reset();
    @(negedge clock);
    check("reset_rf_write", rf_write, 1'b0);
    check("reset_pending", pending, 32'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_a_ready", a_if.ready, 1'b1);
    check_outputs();
    #2 reset = 1'b1;

    // Single A write r3 = 1
    cycle(1'b1, 5'd3, 64'h1, 1'b0, 5'd0, 64'd0);
    check("t1_pending3_queued", pending[3], 1'b1);
    check("t1_rf_write_low", rf_write, 1'b0);
    idle(1);
    check("t1_rf_write", rf_write, 1'b1);
    check("t1_rf_address", rf_address, 5'd3);
    check("t1_rf_data", rf_data, 64'h1);
    check("t1_pending3_on_rf", pending[3], 1'b1);
    idle(1);
    check("t1_rf_write_done", rf_write, 1'b0);
    check("t1_pending3_clear", pending[3], 1'b0);
    check("t1_busy_clear", busy, 1'b0);

    // Both saturating: grants alternate A,B,... starting with A after reset
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 5'd10, 64'hA000 + 64'(i), 1'b1, 5'd20, 64'hB000 + 64'(i));
      if (i >= 1) begin
        check("t2_rf_write_high", rf_write, 1'b1);
        check("t2_source", rf_data[15:12], (i % 2 == 1) ? 4'hA : 4'hB);
      end
    end
    idle(6);

    // A fills while B takes every other grant
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd1 + 5'(i), 64'hC0 + 64'(i), 1'b1, 5'd9, 64'hD0 + 64'(i));
      if (i == 2) check("t3_a_ready_full", a_if.ready, 1'b0);
      if (i == 1) check("t3_b_ready_full", b_if.ready, 1'b0);
    end
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0 || m_write); i++) idle(1);
    check("t3_drained", busy, 1'b0);

    // Zero-register write from B is accepted and dropped
    pulse_reset();
    check("t4_b_ready", b_if.ready, 1'b1);
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hDEAD);
    check("t4_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("t4_rf_write", rf_write, 1'b0);
      check("t4_pending31", pending[31], 1'b0);
    end

    // Same target from both requesters
    pulse_reset();
    cycle(1'b1, 5'd7, 64'h71, 1'b1, 5'd7, 64'h72);
    check("t5_pending7_q", pending[7], 1'b1);
    idle(1);
    check("t5_pending7_first", pending[7], 1'b1);
    idle(1);
    check("t5_pending7_second", pending[7], 1'b1);
    check("t5_second_data", rf_data, 64'h72);
    idle(1);
    check("t5_pending7_clear", pending[7], 1'b0);

    // Reset with three writes in flight
    pulse_reset();
    cycle(1'b1, 5'd4, 64'h44, 1'b1, 5'd5, 64'h55);
    cycle(1'b1, 5'd6, 64'h66, 1'b0, 5'd0, 64'd0);
    check("t6_busy_before", busy, 1'b1);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #2 reset = 1'b0;
    #1;
    check("t6_rf_write", rf_write, 1'b0);
    check("t6_pending", pending, 32'd0);
    check("t6_busy", busy, 1'b0);
`ifdef REGFILE_ARB_STALL_COUNT_EN
    check("t6_stall_a", stall_count_a, 16'd0);
    check("t6_stall_b", stall_count_b, 16'd0);
`endif
    model_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("t6_no_write", rf_write, 1'b0);
    end

    // Randomized traffic
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    idle(8);
    check("final_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
